sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Single-port SRAM controller that shares one SRAM macro between an independent write requester and read requester, such as the write and read channels of an AXI-lite slave bridge. It zero-fills the SRAM after reset. It arbitrates round-robin, one access per cycle, and returns read data through a 2-entry response buffer with valid/ready backpressure. It sits between the bus-protocol front end and the SRAM macro.

## Interface
Parameters:
- SRAM_DATA_WIDTH, 32, SRAM word width in bits.
- SRAM_ADDR_WIDTH, 8, SRAM word address width; depth is 2**SRAM_ADDR_WIDTH.
- SRAM_STRB_WIDTH, 8, bits per write-enable lane. SRAM_DATA_WIDTH must be a multiple of it. The lane count is NLANE = SRAM_DATA_WIDTH/SRAM_STRB_WIDTH.

Ports:
- AIX_CLK  in  1  clock. All logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- WR_REQ_VALID  in  1  write request valid.
- WR_REQ_READY  out  1  write request accepted this cycle.
- WR_ADDR  in  SRAM_ADDR_WIDTH  write word address.
- WR_DATA  in  SRAM_DATA_WIDTH  write data.
- WR_STRB  in  NLANE  per-lane write enable.
- RD_REQ_VALID  in  1  read request valid.
- RD_REQ_READY  out  1  read request accepted this cycle.
- RD_ADDR  in  SRAM_ADDR_WIDTH  read word address.
- RD_RSP_VALID  out  1  read data valid.
- RD_RSP_READY  in  1  consumer takes read data.
- RD_RSP_DATA  out  SRAM_DATA_WIDTH  read data.
- SRAM_CS  out  1  SRAM access enable.
- SRAM_W_EN  out  NLANE  per-lane write enable; all zeros means a read.
- SRAM_ADDR  out  SRAM_ADDR_WIDTH  SRAM address.
- SRAM_DATA_W  out  SRAM_DATA_WIDTH  SRAM write data.
- SRAM_DATA_R  in  SRAM_DATA_WIDTH  SRAM read data, valid the cycle after a read access.
- WR_GRANT_CNT, RD_GRANT_CNT  out  32 each  grant counters; present only with SRAM_ARB_PERF_CNT_EN.

## Operation
- The FSM has three states: RST_WAIT, INIT, RUN.
  - RST_WAIT is the reset state. It moves to INIT on the first clock edge after RST falls.
  - INIT writes all-zero data to address init_cnt with SRAM_CS=1 and SRAM_W_EN all ones. init_cnt increments each cycle from 0.
  - After writing address 2**SRAM_ADDR_WIDTH-1, INIT moves to RUN.
  - In RST_WAIT and INIT, both REQ_READY outputs are 0.
- In RUN, requester eligibility:
  - The write requester is eligible when WR_REQ_VALID=1.
  - The read requester is eligible when RD_REQ_VALID=1 and the read credit holds: buf_occ + rd_inflight - rsp_pop < 2.
  - rsp_pop is RD_RSP_VALID & RD_RSP_READY in the same cycle.
- Grant rules:
  - If one requester is eligible, it is granted.
  - If both are eligible, the requester not granted last is granted. The last-grant register resets to "read", so write wins the first tie.
- The granted requester's READY is 1 combinationally in the same cycle. The non-granted requester's READY is 0.
- SRAM pins are driven combinationally from the granted request.
  - Write grant: SRAM_W_EN=WR_STRB. A write with WR_STRB=0 is still accepted and issues CS with no lanes enabled.
  - Read grant: SRAM_W_EN=0.
  - No grant: SRAM_CS=0, and SRAM_ADDR, SRAM_DATA_W and SRAM_W_EN are 0.
- Read-data path:
  - rd_inflight is set on a read grant.
  - In the next cycle SRAM_DATA_R is pushed into the FIFO buffer.
  - The buffer head drives RD_RSP_DATA while RD_RSP_VALID=1.
- Buffer boundaries:
  - Push and pop in the same cycle on a full buffer are legal.
  - Push on a full buffer without a pop cannot occur because of the credit rule. The bench must flag one.
- Reset mid-operation: asynchronously returns to RST_WAIT.
  - The buffer is flushed, rd_inflight is cleared, init_cnt returns to 0, and the SRAM contents are re-zeroed.

## Timing
- Reset values: WR_REQ_READY=0, RD_REQ_READY=0, RD_RSP_VALID=0, RD_RSP_DATA=0, SRAM_CS=0, SRAM_W_EN=0, SRAM_ADDR=0, SRAM_DATA_W=0, counters=0.
- INIT takes 2**SRAM_ADDR_WIDTH cycles. The first RUN grant is possible at cycle 2**SRAM_ADDR_WIDTH+1 after reset release.
- Write: accepted and written in the same cycle N.
- Read accepted in cycle N:
  - The SRAM is accessed in N.
  - Data is captured at the end of N+1.
  - RD_RSP_VALID=1 from N+2.
- Throughput: one read per cycle is sustained while RD_RSP_READY stays 1. With RD_RSP_READY held 0, at most 2 reads are accepted.
- RD_RSP_VALID and RD_RSP_DATA stay stable until popped.

## Configuration
- SRAM_ARB_PERF_CNT_EN defined:
  - WR_GRANT_CNT and RD_GRANT_CNT exist.
  - Each increments on its own grant in RUN only, wraps modulo 2**32, and resets to 0.
- SRAM_ARB_PERF_CNT_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package sram_arb_pkg holds:
  - the state enum (RST_WAIT, INIT, RUN);
  - the grant enum (GNT_NONE, GNT_WR, GNT_RD);
  - the constant RSP_BUF_DEPTH=2.
- Sub-module sram_rsp_buf: 2-entry synchronous FIFO with push, pop, occupancy, head data, and asynchronous flush on RST.
- The top level holds the FSM, init_cnt, the arbiter, credit tracking and counters.

## Test plan
- SRAM_ADDR_WIDTH=4; release reset:
  - expect 16 cycles of SRAM_CS=1, SRAM_W_EN all ones, ADDR 0..15, DATA 0;
  - expect both READY low during that time;
  - expect RUN on cycle 17.
- Write 0xDEADBEEF to address 3 with WR_STRB=0b0101, then read address 3:
  - expect RD_RSP_DATA=0x00AD00EF two cycles after read acceptance.
- Hold WR_REQ_VALID and RD_REQ_VALID high for 8 cycles:
  - expect grants W,R,W,R,W,R,W,R;
  - with the macro enabled, expect WR_GRANT_CNT=RD_GRANT_CNT=4.
- Hold RD_RSP_READY=0 and RD_REQ_VALID=1:
  - expect exactly 2 reads accepted, then RD_REQ_READY=0;
  - raise RD_RSP_READY and expect both responses in order and one read accepted per cycle thereafter.
- Assert RST while one read is in flight and the buffer holds 1 entry:
  - expect RD_RSP_VALID=0 immediately;
  - expect INIT to restart;
  - expect a later read of that address to return 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a. Holds the FSM state enum, grant enum and response buffer depth.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    INIT     = 2'd1,
    RUN      = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } arb_gnt_e;

  localparam int unsigned RSP_BUF_DEPTH = 2;
  localparam logic [1:0]  RSP_BUF_FULL  = 2'(RSP_BUF_DEPTH);

endpackage

// File: rtl/sram_rsp_buf.sv
// Two-entry read-response FIFO; push_data_i lands at the head one cycle after push_i.
// Latency: 1 cycle push-to-head. Push on full is dropped unless a pop happens in the same cycle.
// Backpressure: the owner must keep pushes within free space (credit); rst_i flushes asynchronously.
// Ports: clk_i, rst_i, push_i/push_data_i (write side), pop_i (consume head),
//        occ_o (0..2 entries held), head_data_o (oldest entry).
module sram_rsp_buf
  import sram_arb_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [1:0]    occ_o,
  output logic [DW-1:0] head_data_o
);

  logic [DW-1:0] mem_q [RSP_BUF_DEPTH];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    occ_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i && (occ_q != 2'd0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((occ_q != RSP_BUF_FULL) || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign occ_o       = occ_q;
  assign head_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between a write and a read requester, zero-filling it after reset.
// Latency: write takes effect in its grant cycle; read data is valid two cycles after acceptance.
// Backpressure: round-robin, one grant per cycle; reads are credit-limited to the 2-entry response buffer.
// Ports: AIX_CLK/RST; WR_REQ_* write request; RD_REQ_*/RD_ADDR read request; RD_RSP_* response;
//        SRAM_* macro pins; WR_GRANT_CNT/RD_GRANT_CNT only when SRAM_ARB_PERF_CNT_EN is defined.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int SRAM_ADDR_WIDTH = 8,
  parameter int SRAM_STRB_WIDTH = 8,
  localparam int NLANE = SRAM_DATA_WIDTH / SRAM_STRB_WIDTH
) (
  input  logic                       AIX_CLK,
  input  logic                       RST,
  input  logic                       WR_REQ_VALID,
  output logic                       WR_REQ_READY,
  input  logic [SRAM_ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [SRAM_DATA_WIDTH-1:0] WR_DATA,
  input  logic [NLANE-1:0]           WR_STRB,
  input  logic                       RD_REQ_VALID,
  output logic                       RD_REQ_READY,
  input  logic [SRAM_ADDR_WIDTH-1:0] RD_ADDR,
  output logic                       RD_RSP_VALID,
  input  logic                       RD_RSP_READY,
  output logic [SRAM_DATA_WIDTH-1:0] RD_RSP_DATA,
  output logic                       SRAM_CS,
  output logic [NLANE-1:0]           SRAM_W_EN,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [SRAM_DATA_WIDTH-1:0] SRAM_DATA_W,
  input  logic [SRAM_DATA_WIDTH-1:0] SRAM_DATA_R
`ifdef SRAM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                WR_GRANT_CNT,
  output logic [31:0]                RD_GRANT_CNT
`endif
);

  localparam logic [SRAM_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  arb_state_e                 state_q, state_d;
  logic [SRAM_ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                       last_rd_q, last_rd_d;   // 1: most recent grant went to the reader
  logic                       rd_inflight_q;
  arb_gnt_e                   gnt;
  logic [1:0]                 buf_occ;
  logic [SRAM_DATA_WIDTH-1:0] buf_head;
  logic                       rsp_pop;
  logic                       rd_credit_ok;
  logic                       wr_elig;
  logic                       rd_elig;

  assign RD_RSP_VALID = (buf_occ != 2'd0);
  assign rsp_pop      = RD_RSP_VALID && RD_RSP_READY;
  assign RD_RSP_DATA  = RD_RSP_VALID ? buf_head : '0;

  // Entries held plus the read still in the SRAM must leave room, counting a slot freed this cycle.
  assign rd_credit_ok = ({1'b0, buf_occ} + {2'b00, rd_inflight_q}) < (3'd2 + {2'b00, rsp_pop});
  assign wr_elig      = (state_q == RUN) && WR_REQ_VALID;
  assign rd_elig      = (state_q == RUN) && RD_REQ_VALID && rd_credit_ok;

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    last_rd_d    = last_rd_q;
    gnt          = GNT_NONE;
    WR_REQ_READY = 1'b0;
    RD_REQ_READY = 1'b0;
    SRAM_CS      = 1'b0;
    SRAM_W_EN    = '0;
    SRAM_ADDR    = '0;
    SRAM_DATA_W  = '0;

    case (state_q)
      RST_WAIT: state_d = INIT;
      INIT: begin
        SRAM_CS    = 1'b1;
        SRAM_W_EN  = '1;
        SRAM_ADDR  = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;   // wraps back to 0 for the next reset
        if (init_cnt_q == LAST_ADDR) state_d = RUN;
      end
      RUN: begin
        if (wr_elig && (!rd_elig || last_rd_q)) gnt = GNT_WR;
        else if (rd_elig)                       gnt = GNT_RD;
      end
      default: state_d = RST_WAIT;
    endcase

    case (gnt)
      GNT_WR: begin
        WR_REQ_READY = 1'b1;
        SRAM_CS      = 1'b1;
        SRAM_W_EN    = WR_STRB;
        SRAM_ADDR    = WR_ADDR;
        SRAM_DATA_W  = WR_DATA;
        last_rd_d    = 1'b0;
      end
      GNT_RD: begin
        RD_REQ_READY = 1'b1;
        SRAM_CS      = 1'b1;
        SRAM_ADDR    = RD_ADDR;
        last_rd_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge AIX_CLK or posedge RST) begin
    if (RST) begin
      state_q       <= RST_WAIT;
      init_cnt_q    <= '0;
      last_rd_q     <= 1'b1;
      rd_inflight_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      last_rd_q     <= last_rd_d;
      rd_inflight_q <= (gnt == GNT_RD);
    end
  end

  // SRAM_DATA_R is valid the cycle after the read access, exactly while rd_inflight_q is set.
  sram_rsp_buf #(.DW(SRAM_DATA_WIDTH)) u_rsp_buf (
    .clk_i       (AIX_CLK),
    .rst_i       (RST),
    .push_i      (rd_inflight_q),
    .push_data_i (SRAM_DATA_R),
    .pop_i       (rsp_pop),
    .occ_o       (buf_occ),
    .head_data_o (buf_head)
  );

`ifdef SRAM_ARB_PERF_CNT_EN
  logic [31:0] wr_cnt_q;
  logic [31:0] rd_cnt_q;

  // Grants only occur in RUN, so no extra state qualification is needed.
  always_ff @(posedge AIX_CLK or posedge RST) begin
    if (RST) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (gnt == GNT_WR) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (gnt == GNT_RD) rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign WR_GRANT_CNT = wr_cnt_q;
  assign RD_GRANT_CNT = rd_cnt_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM and a read-response scoreboard.
module tb_sram_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NL = 4;

  logic          AIX_CLK = 1'b0;
  logic          RST;
  logic          WR_REQ_VALID, WR_REQ_READY;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic [NL-1:0] WR_STRB;
  logic          RD_REQ_VALID, RD_REQ_READY;
  logic [AW-1:0] RD_ADDR;
  logic          RD_RSP_VALID, RD_RSP_READY;
  logic [DW-1:0] RD_RSP_DATA;
  logic          SRAM_CS;
  logic [NL-1:0] SRAM_W_EN;
  logic [AW-1:0] SRAM_ADDR;
  logic [DW-1:0] SRAM_DATA_W;
  logic [DW-1:0] SRAM_DATA_R;
`ifdef SRAM_ARB_PERF_CNT_EN
  logic [31:0]   WR_GRANT_CNT, RD_GRANT_CNT;
`endif

  always #5 AIX_CLK = ~AIX_CLK;

  sram_port_arbiter #(
    .SRAM_DATA_WIDTH(DW),
    .SRAM_ADDR_WIDTH(AW),
    .SRAM_STRB_WIDTH(8)
  ) dut (
    .AIX_CLK      (AIX_CLK),
    .RST          (RST),
    .WR_REQ_VALID (WR_REQ_VALID),
    .WR_REQ_READY (WR_REQ_READY),
    .WR_ADDR      (WR_ADDR),
    .WR_DATA      (WR_DATA),
    .WR_STRB      (WR_STRB),
    .RD_REQ_VALID (RD_REQ_VALID),
    .RD_REQ_READY (RD_REQ_READY),
    .RD_ADDR      (RD_ADDR),
    .RD_RSP_VALID (RD_RSP_VALID),
    .RD_RSP_READY (RD_RSP_READY),
    .RD_RSP_DATA  (RD_RSP_DATA),
    .SRAM_CS      (SRAM_CS),
    .SRAM_W_EN    (SRAM_W_EN),
    .SRAM_ADDR    (SRAM_ADDR),
    .SRAM_DATA_W  (SRAM_DATA_W),
    .SRAM_DATA_R  (SRAM_DATA_R)
`ifdef SRAM_ARB_PERF_CNT_EN
    ,
    .WR_GRANT_CNT (WR_GRANT_CNT),
    .RD_GRANT_CNT (RD_GRANT_CNT)
`endif
  );

  // Behavioural single-port SRAM, seeded with junk so the zero-fill is observable.
  logic [DW-1:0] sram_mem [16];
  logic          seeded = 1'b0;
  always @(posedge AIX_CLK) begin
    if (!seeded) begin
      for (int i = 0; i < 16; i++) sram_mem[i] <= 32'hA5A5A5A5;
      seeded <= 1'b1;
    end else if (SRAM_CS) begin
      if (SRAM_W_EN == '0) SRAM_DATA_R <= sram_mem[SRAM_ADDR];
      else
        for (int l = 0; l < NL; l++)
          if (SRAM_W_EN[l]) sram_mem[SRAM_ADDR][l*8 +: 8] <= SRAM_DATA_W[l*8 +: 8];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: expected stored words are hand-computed by the stimulus and recorded on write
  // acceptance; read acceptance queues the expected word; responses are compared on pop.
  logic [31:0] wr_stored;
  logic [31:0] exp_mem [16];
  logic [31:0] exp_q [$];
  int          outstanding;

  always @(negedge AIX_CLK) begin
    if (RST) begin
      exp_q.delete();
      outstanding = 0;
      for (int i = 0; i < 16; i++) exp_mem[i] = 32'h0;
    end else begin
      if (RD_RSP_VALID && RD_RSP_READY) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got 0x%08h with no read outstanding", RD_RSP_DATA);
        end else begin
          check("rsp_data", RD_RSP_DATA, exp_q.pop_front());
        end
        outstanding--;
      end
      if (WR_REQ_VALID && WR_REQ_READY) exp_mem[WR_ADDR] = wr_stored;
      if (RD_REQ_VALID && RD_REQ_READY) begin
        exp_q.push_back(exp_mem[RD_ADDR]);
        outstanding++;
        // More than two reads between acceptance and pop would mean a push onto a full buffer.
        check("rd_outstanding_le_2", 32'(outstanding <= 2), 32'd1);
      end
    end
  end

  task automatic drive_edge();
    @(posedge AIX_CLK);
    #1;
  endtask

  int acc;
  int cyc;

  initial begin
    RST = 1'b1;
    WR_REQ_VALID = 1'b0; WR_ADDR = '0; WR_DATA = '0; WR_STRB = '0; wr_stored = '0;
    RD_REQ_VALID = 1'b0; RD_ADDR = '0; RD_RSP_READY = 1'b1;
    repeat (3) drive_edge();

    // Reset values
    @(negedge AIX_CLK);
    check("rst_wr_ready",  32'(WR_REQ_READY), 32'd0);
    check("rst_rd_ready",  32'(RD_REQ_READY), 32'd0);
    check("rst_rsp_valid", 32'(RD_RSP_VALID), 32'd0);
    check("rst_rsp_data",  RD_RSP_DATA, 32'd0);
    check("rst_cs",        32'(SRAM_CS), 32'd0);
    check("rst_w_en",      32'(SRAM_W_EN), 32'd0);
    check("rst_addr",      32'(SRAM_ADDR), 32'd0);
    check("rst_data_w",    SRAM_DATA_W, 32'd0);
`ifdef SRAM_ARB_PERF_CNT_EN
    check("rst_wr_cnt", WR_GRANT_CNT, 32'd0);
    check("rst_rd_cnt", RD_GRANT_CNT, 32'd0);
`endif

    // Release with both requesters already asking: they must wait out INIT.
    drive_edge();
    RST = 1'b0;
    WR_REQ_VALID = 1'b1; WR_ADDR = 4'd5; WR_DATA = 32'hCAFEF00D; WR_STRB = 4'hF;
    wr_stored = 32'hCAFEF00D;
    RD_REQ_VALID = 1'b1; RD_ADDR = 4'd5;
    @(negedge AIX_CLK);
    check("rstwait_cs", 32'(SRAM_CS), 32'd0);
    for (int c = 0; c < 16; c++) begin
      @(negedge AIX_CLK);
      check("init_cs",       32'(SRAM_CS), 32'd1);
      check("init_w_en",     32'(SRAM_W_EN), 32'hF);
      check("init_addr",     32'(SRAM_ADDR), 32'(c));
      check("init_data_w",   SRAM_DATA_W, 32'd0);
      check("init_wr_ready", 32'(WR_REQ_READY), 32'd0);
      check("init_rd_ready", 32'(RD_REQ_READY), 32'd0);
    end

    // Cycle 17 onward: alternating grants, write first.
    for (int g = 0; g < 8; g++) begin
      @(negedge AIX_CLK);
      check("rr_wr_grant", 32'(WR_REQ_READY), 32'((g % 2) == 0));
      check("rr_rd_grant", 32'(RD_REQ_READY), 32'((g % 2) == 1));
    end
    drive_edge();
    WR_REQ_VALID = 1'b0; RD_REQ_VALID = 1'b0;
    @(negedge AIX_CLK);
    check("idle_cs",     32'(SRAM_CS), 32'd0);
    check("idle_w_en",   32'(SRAM_W_EN), 32'd0);
    check("idle_addr",   32'(SRAM_ADDR), 32'd0);
    check("idle_data_w", SRAM_DATA_W, 32'd0);
`ifdef SRAM_ARB_PERF_CNT_EN
    check("rr_wr_cnt", WR_GRANT_CNT, 32'd4);
    check("rr_rd_cnt", RD_GRANT_CNT, 32'd4);
`endif
    repeat (3) drive_edge();

    // Partial-lane write: lanes 0 and 2 of 0xDEADBEEF over a zeroed word.
    WR_REQ_VALID = 1'b1; WR_ADDR = 4'd3; WR_DATA = 32'hDEADBEEF; WR_STRB = 4'b0101;
    wr_stored = 32'h00AD00EF;
    @(negedge AIX_CLK);
    check("wr_ready",   32'(WR_REQ_READY), 32'd1);
    check("wr_cs",      32'(SRAM_CS), 32'd1);
    check("wr_w_en",    32'(SRAM_W_EN), 32'h5);
    check("wr_addr",    32'(SRAM_ADDR), 32'd3);
    check("wr_data_w",  SRAM_DATA_W, 32'hDEADBEEF);
    // Strobe-less write: accepted, CS with no lanes, memory unchanged.
    drive_edge();
    WR_ADDR = 4'd6; WR_DATA = 32'hFFFFFFFF; WR_STRB = 4'b0000; wr_stored = 32'h0;
    @(negedge AIX_CLK);
    check("wr0_ready", 32'(WR_REQ_READY), 32'd1);
    check("wr0_cs",    32'(SRAM_CS), 32'd1);
    check("wr0_w_en",  32'(SRAM_W_EN), 32'h0);
    drive_edge();
    WR_REQ_VALID = 1'b0;
    RD_REQ_VALID = 1'b1; RD_ADDR = 4'd3;
    @(negedge AIX_CLK);
    check("rd_ready", 32'(RD_REQ_READY), 32'd1);
    check("rd_w_en",  32'(SRAM_W_EN), 32'h0);
    check("rd_addr",  32'(SRAM_ADDR), 32'd3);
    drive_edge();
    RD_REQ_VALID = 1'b0;
    @(negedge AIX_CLK);
    check("rd_lat_n1_valid", 32'(RD_RSP_VALID), 32'd0);
    @(negedge AIX_CLK);
    check("rd_lat_n2_valid", 32'(RD_RSP_VALID), 32'd1);
    check("rd_lat_n2_data",  RD_RSP_DATA, 32'h00AD00EF);
    repeat (2) drive_edge();

    // Backpressure: consumer stalled, only two reads may be taken.
    RD_RSP_READY = 1'b0; RD_REQ_VALID = 1'b1; RD_ADDR = 4'd3;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge AIX_CLK);
      if (RD_REQ_VALID && RD_REQ_READY) acc++;
      drive_edge();
      if (acc >= 1) RD_ADDR = 4'd6;
    end
    check("bp_accepts", 32'(acc), 32'd2);
    @(negedge AIX_CLK);
    check("bp_rd_ready",  32'(RD_REQ_READY), 32'd0);
    check("bp_rsp_valid", 32'(RD_RSP_VALID), 32'd1);
    check("bp_rsp_head",  RD_RSP_DATA, 32'h00AD00EF);
    drive_edge();
    RD_RSP_READY = 1'b1; RD_ADDR = 4'd5;
    for (int k = 0; k < 6; k++) begin
      @(negedge AIX_CLK);
      check("bp_release_rd_ready", 32'(RD_REQ_READY), 32'd1);
      drive_edge();
    end
    RD_REQ_VALID = 1'b0;
    repeat (4) drive_edge();
    check("sb_drained_1", 32'(exp_q.size()), 32'd0);

    // Reset with one read in flight and one entry buffered.
    RD_RSP_READY = 1'b0; RD_REQ_VALID = 1'b1; RD_ADDR = 4'd3;
    acc = 0;
    for (int k = 0; k < 10 && acc < 2; k++) begin
      @(negedge AIX_CLK);
      if (RD_REQ_VALID && RD_REQ_READY) acc++;
      if (acc < 2) drive_edge();
    end
    check("mid_accepts", 32'(acc), 32'd2);
    drive_edge();
    RD_REQ_VALID = 1'b0;
    @(negedge AIX_CLK);
    check("mid_pre_rsp_valid", 32'(RD_RSP_VALID), 32'd1);
    #1 RST = 1'b1;
    #1;
    check("mid_rst_rsp_valid", 32'(RD_RSP_VALID), 32'd0);
    check("mid_rst_rsp_data",  RD_RSP_DATA, 32'd0);
    check("mid_rst_cs",        32'(SRAM_CS), 32'd0);
    repeat (2) drive_edge();
    RST = 1'b0; RD_RSP_READY = 1'b1; RD_REQ_VALID = 1'b1; RD_ADDR = 4'd3;
    cyc = 0;
    for (int c = 0; c <= 40; c++) begin
      @(negedge AIX_CLK);
      cyc = c;
      if (c == 1) begin
        check("reinit_cs",   32'(SRAM_CS), 32'd1);
        check("reinit_w_en", 32'(SRAM_W_EN), 32'hF);
        check("reinit_addr", 32'(SRAM_ADDR), 32'd0);
      end
      if (RD_REQ_READY) break;
    end
    check("reinit_first_grant_cycle", 32'(cyc), 32'd17);
    drive_edge();
    RD_REQ_VALID = 1'b0;
    repeat (4) drive_edge();
    check("sb_drained_2", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
